mem_port_arbiter: RTL

//  Shares the single unified instruction/data memory of the multi-cycle processor between two requesters:
//  the CPU port (driven from the controller's MemRead/MemWrite and the IorD-selected address) and a debug/loader port.

---
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified instruction/data memory of the multi-cycle
// processor between the CPU port and a debug/loader port. One access is in
// flight at a time. On contention the requester that did not win last time is
// granted. Each access completes with a one-cycle ack and registered read data.
//
// The CPU controller holds its fetch/load/store state until cpu_ack, so any
// cycles spent waiting here look like ordinary stall cycles to the CPU.
//
// Parameters
//   AW       address width, both requesters and the memory
//   DW       data width
//   MEM_LAT  memory read latency in cycles (must be >= 1)
//
// Ports
//   clk                     single clock, all state updates on posedge
//   rst                     synchronous reset, active-low (0 = reset)
//   cpu_req / dbg_req       access request, held until the matching ack
//   cpu_we / dbg_we         1 = write, 0 = read
//   cpu_addr / dbg_addr     requester address
//   cpu_wdata / dbg_wdata   requester write data
//   cpu_rdata / dbg_rdata   registered read data, valid with the ack
//   cpu_ack / dbg_ack       one-cycle completion pulse
//   mem_addr / mem_wdata    memory address and write data (0 outside ACCESS)
//   mem_read / mem_write    memory strobes
//   mem_rdata               memory read data, MEM_LAT cycles after mem_read
//   busy                    1 while an access is in ACCESS or DONE
//   owner                   0 = CPU, 1 = debug; 0 whenever busy = 0
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Owner encoding shared by owner_q and last_owner_q.
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    // The counter clears on entry to ACCESS and stops at MEM_LAT-1, so it
    // never wraps.
    localparam int            CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state_q,      state_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic          last_owner_q, last_owner_d;
    logic          owner_q,      owner_d;
    logic          we_q,         we_d;
    logic [AW-1:0] addr_q,       addr_d;
    logic [DW-1:0] wdata_q,      wdata_d;
    logic [DW-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q,  dbg_rdata_d;
    logic          grant_dbg;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        grant_dbg    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cpu_req || dbg_req) begin
                    // Debug wins when it is alone, or when both ask and the
                    // CPU was served last.
                    grant_dbg    = dbg_req && (!cpu_req || (last_owner_q == OWN_CPU));
                    owner_d      = grant_dbg;
                    last_owner_d = grant_dbg;
                    we_d         = grant_dbg ? dbg_we    : cpu_we;
                    addr_d       = grant_dbg ? dbg_addr  : cpu_addr;
                    wdata_d      = grant_dbg ? dbg_wdata : cpu_wdata;
                    cnt_d        = '0;
                    state_d      = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    // Only the value present at the end of the last ACCESS
                    // cycle is captured; writes leave both rdata registers.
                    if (!we_q) begin
                        if (owner_q == OWN_DBG) dbg_rdata_d = mem_rdata;
                        else                    cpu_rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DONE: begin
                // A request still high here is only looked at again in IDLE.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_owner_q <= OWN_DBG;
            owner_q      <= OWN_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (decoded from registered state only)
    // -------------------------------------------------------------------------
    logic in_access;
    logic in_done;

    assign in_access = (state_q == S_ACCESS);
    assign in_done   = (state_q == S_DONE);

    // The address and data buses stay at 0 outside ACCESS.
    assign mem_addr  = in_access ? addr_q  : '0;
    assign mem_wdata = in_access ? wdata_q : '0;
    assign mem_read  = in_access && !we_q;
    // A write is strobed once, in the first ACCESS cycle.
    assign mem_write = in_access && we_q && (cnt_q == '0);

    assign cpu_ack   = in_done && (owner_q == OWN_CPU);
    assign dbg_ack   = in_done && (owner_q == OWN_DBG);
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

    assign busy      = in_access || in_done;
    assign owner     = busy && owner_q;

endmodule
